// File: rtl/counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared defaults and direction encoding for mod_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_MAX_VAL  = 15;
    localparam int unsigned DEF_PRESCALE = 1;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/counter_prescaler.sv
// ============================================================================
//  Module      : counter_prescaler
//  Description : Divides enabled cycles by PRESCALE; step marks the last phase.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // No phase state needed: every enabled, non-cleared cycle steps.
            logic unused_ok;
            assign unused_ok = clk ^ rst;
            assign step      = en & ~clr;
        end else begin : g_div
            localparam int unsigned     c_PW   = $clog2(PRESCALE);
            localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

            logic [c_PW-1:0] phase_q;
            logic [c_PW-1:0] phase_d;

            always_comb begin
                phase_d = phase_q;
                if (clr) begin
                    phase_d = '0;
                end else if (en) begin
                    phase_d = (phase_q == c_LAST) ? '0 : phase_q + c_PW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign step = en & ~clr & (phase_q == c_LAST);
        end
    endgenerate

endmodule : counter_prescaler

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
//  Module      : mod_counter
//  Description : Up/down modulo counter with load, prescaler, tc and wrap.
//                Define COUNTER_SAT_EN to saturate at the bounds instead of
//                wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_VAL  = DEF_MAX_VAL,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_counter: WIDTH must be in 1..32");
        end
        if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("mod_counter: MAX_VAL exceeds 2**WIDTH-1");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be at least 1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
`ifdef COUNTER_SAT_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [WIDTH-1:0] eff_w;
    logic             step_w;
    dir_e             dir_w;

    assign dir_w = dir_e'(up);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step_w)
    );

    // Out-of-range counts behave as the terminal value on a step.
    assign eff_w = (count_q > c_MAX) ? c_MAX : count_q;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > c_MAX) ? c_MAX : load_val;
        end else if (step_w) begin
            if (dir_w == DIR_UP) begin
                if (eff_w < c_MAX) begin
                    count_d = eff_w + WIDTH'(1);
                end else if (c_SAT) begin
                    count_d = c_MAX;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (eff_w != '0) begin
                    count_d = eff_w - WIDTH'(1);
                end else if (c_SAT) begin
                    count_d = '0;
                end else begin
                    count_d = c_MAX;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = ((dir_w == DIR_UP)   && (count_q == c_MAX)) ||
                   ((dir_w == DIR_DOWN) && (count_q == '0));

endmodule : mod_counter

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Scoreboard bench for mod_counter (PRESCALE=1 and PRESCALE=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

    localparam int MAXV = 9;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int idx;
        int cnt;
        bit wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_s  [2];
    logic       en_s   [2];
    logic       up_s   [2];
    logic       load_s [2];
    logic [3:0] lv_s   [2];
    logic [3:0] count_s[2];
    logic       tc_s   [2];
    logic       wrap_s [2];

    int   m_cnt[2];
    int   m_pre[2];
    int   wrap_seen[2];
    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1)) u_dut_a (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .up(up_s[0]), .load(load_s[0]),
        .load_val(lv_s[0]), .count(count_s[0]), .tc(tc_s[0]), .wrap(wrap_s[0])
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(3)) u_dut_b (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .up(up_s[1]), .load(load_s[1]),
        .load_val(lv_s[1]), .count(count_s[1]), .tc(tc_s[1]), .wrap(wrap_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ps_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference behaviour for one clock edge; result queued for the edge check.
    function automatic void model_step(input int i);
        bit w = 1'b0;
        if (rst_s[i]) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end else if (load_s[i]) begin
            m_cnt[i] = (int'(lv_s[i]) > MAXV) ? MAXV : int'(lv_s[i]);
            m_pre[i] = 0;
        end else if (en_s[i]) begin
            if (m_pre[i] == ps_of(i) - 1) begin
                m_pre[i] = 0;
                if (up_s[i]) begin
                    if (m_cnt[i] < MAXV) m_cnt[i]++;
                    else if (!SAT) begin m_cnt[i] = 0; w = 1'b1; end
                end else begin
                    if (m_cnt[i] > 0) m_cnt[i]--;
                    else if (!SAT) begin m_cnt[i] = MAXV; w = 1'b1; end
                end
            end else begin
                m_pre[i]++;
            end
        end
        sb.push_back('{i, m_cnt[i], w});
    endfunction

    task automatic tick(input string tag);
        exp_t e;
        bit   exp_tc;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_count"}, 32'(count_s[e.idx]), e.cnt);
                chk({tag, "_wrap"}, 32'(wrap_s[e.idx]), 32'(e.wrap));
                if (wrap_s[e.idx] === 1'b1) wrap_seen[e.idx]++;
                exp_tc = (up_s[e.idx] && e.cnt == MAXV) || (!up_s[e.idx] && e.cnt == 0);
                chk({tag, "_tc"}, 32'(tc_s[e.idx]), 32'(exp_tc));
            end
        end
    endtask

    task automatic drive(input int i, input bit r, input bit e, input bit u,
                         input bit l, input logic [3:0] lv);
        rst_s[i]  = r;
        en_s[i]   = e;
        up_s[i]   = u;
        load_s[i] = l;
        lv_s[i]   = lv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dn_exp[3];
        int ps_exp[6];
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
            wrap_seen[i] = 0;
            drive(i, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        end
        @(negedge clk);

        // Reset overrides load and en
        drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        drive(1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        tick("rst");
        tick("rst");
        chk("rst_count_a", 32'(count_s[0]), 0);
        chk("rst_wrap_a", 32'(wrap_s[0]), 0);

        // Up-wrap on the unscaled counter
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        wrap_seen[0] = 0;
        for (int c = 1; c <= 10; c++) begin
            tick("upwrap");
            chk("upwrap_seq", 32'(count_s[0]), (c == 10) ? (SAT ? MAXV : 0) : c);
        end
        chk("upwrap_pulses", wrap_seen[0], SAT ? 0 : 1);

        // Down-wrap after loading 2
        drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
        tick("dnload");
        chk("dnload_val", 32'(count_s[0]), 2);
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        wrap_seen[0] = 0;
        dn_exp = '{1, 0, SAT ? 0 : MAXV};
        for (int c = 0; c < 3; c++) begin
            tick("dnwrap");
            chk("dnwrap_seq", 32'(count_s[0]), dn_exp[c]);
        end
        chk("dnwrap_pulses", wrap_seen[0], SAT ? 0 : 1);

        // Count up from 8 for 5 steps (saturates when enabled)
        drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
        tick("satload");
        drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        wrap_seen[0] = 0;
        for (int c = 0; c < 5; c++) tick("sat");
        chk("sat_final", 32'(count_s[0]), SAT ? MAXV : 3);
        chk("sat_tc", 32'(tc_s[0]), SAT ? 1 : 0);
        chk("sat_pulses", wrap_seen[0], SAT ? 0 : 1);
        drive(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Prescale by 3
        drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        ps_exp = '{0, 0, 1, 1, 1, 2};
        for (int c = 0; c < 6; c++) begin
            tick("ps");
            chk("ps_seq", 32'(count_s[1]), ps_exp[c]);
        end
        tick("ps_pause_pre");
        drive(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        for (int c = 0; c < 4; c++) tick("ps_pause");
        chk("ps_paused", 32'(count_s[1]), 2);
        drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick("ps_resume");
        chk("ps_resume_hold", 32'(count_s[1]), 2);
        tick("ps_resume");
        chk("ps_resume_step", 32'(count_s[1]), 3);

        // Reset mid-prescale restarts the phase
        tick("ps_mid");
        drive(1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        tick("ps_rst");
        drive(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        tick("ps_post");
        tick("ps_post");
        chk("ps_post_hold", 32'(count_s[1]), 0);
        tick("ps_post");
        chk("ps_post_step", 32'(count_s[1]), 1);

        // Clamped load clears the prescaler
        tick("ld_pre");
        drive(1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
        tick("ld");
        chk("ld_clamp", 32'(count_s[1]), MAXV);
        chk("ld_wrap", 32'(wrap_s[1]), 0);
        drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        tick("ld_after");
        tick("ld_after");
        chk("ld_after_hold", 32'(count_s[1]), MAXV);
        tick("ld_after");
        chk("ld_after_step", 32'(count_s[1]), MAXV - 1);

        // Random traffic on both counters
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                      4'($urandom_range(0, 15)));
            end
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mod_counter

`default_nettype wire
